// File: rtl/prio_req_sched_pkg.sv
// prio_req_sched_pkg: shared types and constants for the three-channel request scheduler
package prio_req_sched_pkg;
  localparam int NCH = 3;
  localparam int HOLD_DEFAULT = 4;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/prio_req_sched_if.sv
// prio_req_sched_if: request/data inputs and grant/status outputs of the scheduler
interface prio_req_sched_if;
  logic req1, req2, req3;
  logic din1, din2, din3;
  logic c1, c2, c3;
  logic b1, b2, b3;
  logic [2:0] pend;
  logic busy;
  logic done;
  modport master (
    output req1, req2, req3, din1, din2, din3,
    input  c1, c2, c3, b1, b2, b3, pend, busy, done
  );
  modport slave (
    input  req1, req2, req3, din1, din2, din3,
    output c1, c2, c3, b1, b2, b3, pend, busy, done
  );
endinterface

// File: rtl/prio_pick3.sv
// prio_pick3: lowest-index-first one-hot picker over three request bits
module prio_pick3 import prio_req_sched_pkg::*; (
  input  logic [NCH-1:0] r,
  output logic [NCH-1:0] g,
  output logic           v
);
  assign g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
  assign v = |r;
endmodule

// File: rtl/prio_req_sched.sv
// prio_req_sched: sticky per-channel request capture with fixed-priority, fixed-width one-hot grants
module prio_req_sched import prio_req_sched_pkg::*; #(
  parameter int HOLD_CYCLES = HOLD_DEFAULT,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  prio_req_sched_if.slave s
);
  logic [NCH-1:0] req, din, pend_q, dbuf_q, gnt_q, gnt_n, pick, clr, cap;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  state_t st_q, st_n;
  logic done_q, done_n, pv;
  assign req = {s.req3, s.req2, s.req1};
  assign din = {s.din3, s.din2, s.din1};
  prio_pick3 u_pick (.r(pend_q), .g(pick), .v(pv));
  // a request landing on the completing channel re-arms it instead of being ignored
  assign clr = (st_q == GRANT && cnt_q == '0) ? gnt_q : '0;
  assign cap = req & ~(pend_q & ~clr);
  always_comb begin
    st_n = st_q;
    gnt_n = gnt_q;
    cnt_n = cnt_q;
    done_n = 1'b0;
    if (st_q == IDLE) begin
      st_n = pv ? GRANT : IDLE;
      gnt_n = pv ? pick : '0;
      cnt_n = pv ? CNT_W'(HOLD_CYCLES - 1) : cnt_q;
    end else if (cnt_q != '0) begin
      cnt_n = cnt_q - 1'b1;
    end else begin
      st_n = IDLE;
      gnt_n = '0;
      done_n = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      gnt_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      pend_q <= '0;
      dbuf_q <= '0;
    end else begin
      st_q <= st_n;
      gnt_q <= gnt_n;
      cnt_q <= cnt_n;
      done_q <= done_n;
      pend_q <= (pend_q & ~clr) | cap;
      for (int i = 0; i < NCH; i++) dbuf_q[i] <= cap[i] ? din[i] : dbuf_q[i];
    end
  end
  assign {s.c3, s.c2, s.c1} = gnt_q;
  assign {s.b3, s.b2, s.b1} = gnt_q & dbuf_q;
  assign s.pend = pend_q;
  assign s.busy = (st_q == GRANT);
  assign s.done = done_q;
endmodule
